// File: rtl/pl_id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and a saturating stall counter.
// Define ID_WB_BYPASS_EN to forward the writeback result into rd1_e/rd2_e on a source match.
module pl_id_ex_stage #(
   parameter int WAD = 5,
   parameter int WD  = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           valid_d,
   input  logic [WD-1:0]  pc_d,
   input  logic [WD-1:0]  imm_d,
   input  logic [WAD-1:0] rs1_d,
   input  logic [WAD-1:0] rs2_d,
   input  logic [WAD-1:0] rd_d,
   input  logic           use_rs1_d,
   input  logic           use_rs2_d,
   input  logic [WD-1:0]  rd1_d,
   input  logic [WD-1:0]  rd2_d,
   input  logic [11:0]    ctrl_d,
   input  logic           reg_write_w,
   input  logic [WAD-1:0] rd_w,
   input  logic [WD-1:0]  result_w,
   input  logic           flush_e,
   output logic           stall_d,
   output logic           valid_e,
   output logic [WD-1:0]  pc_e,
   output logic [WD-1:0]  imm_e,
   output logic [WAD-1:0] rs1_e,
   output logic [WAD-1:0] rs2_e,
   output logic [WAD-1:0] rd_e,
   output logic [WD-1:0]  rd1_e,
   output logic [WD-1:0]  rd2_e,
   output logic [11:0]    ctrl_e,
   output logic [15:0]    stall_count
);

   typedef struct packed {
      logic           valid;
      logic [WD-1:0]  pc;
      logic [WD-1:0]  imm;
      logic [WAD-1:0] rs1;
      logic [WAD-1:0] rs2;
      logic [WAD-1:0] rd;
      logic [WD-1:0]  rd1;
      logic [WD-1:0]  rd2;
      logic [11:0]    ctrl;
   } ex_t;

   ex_t         ex_q, ex_d;
   logic [15:0] stall_count_q, stall_count_d;
   logic        hazard;
   logic        bubble;
   logic [WD-1:0] op1, op2;

   // Only a load sitting in EX can produce data too late for the next instruction.
   assign hazard = valid_d & ex_q.valid & ex_q.ctrl[10] & (ex_q.rd != '0) &
                   ((use_rs1_d & (rs1_d == ex_q.rd)) | (use_rs2_d & (rs2_d == ex_q.rd)));
   assign stall_d = hazard & ~flush_e;
   assign bubble  = flush_e | stall_d | ~valid_d;

`ifdef ID_WB_BYPASS_EN
   assign op1 = (reg_write_w && (rd_w != '0) && (rd_w == rs1_d)) ? result_w : rd1_d;
   assign op2 = (reg_write_w && (rd_w != '0) && (rd_w == rs2_d)) ? result_w : rd2_d;
`else
   logic unused_wb;
   assign unused_wb = ^{reg_write_w, rd_w, result_w};
   assign op1 = rd1_d;
   assign op2 = rd2_d;
`endif

   always_comb begin
      ex_d          = '0;
      stall_count_d = stall_count_q;
      if (!bubble) begin
         ex_d.valid = 1'b1;
         ex_d.pc    = pc_d;
         ex_d.imm   = imm_d;
         ex_d.rs1   = rs1_d;
         ex_d.rs2   = rs2_d;
         ex_d.rd    = rd_d;
         ex_d.rd1   = op1;
         ex_d.rd2   = op2;
         ex_d.ctrl  = ctrl_d;
      end
      if (stall_d && (stall_count_q != 16'hFFFF)) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q          <= '0;
         stall_count_q <= '0;
      end else begin
         ex_q          <= ex_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign valid_e     = ex_q.valid;
   assign pc_e        = ex_q.pc;
   assign imm_e       = ex_q.imm;
   assign rs1_e       = ex_q.rs1;
   assign rs2_e       = ex_q.rs2;
   assign rd_e        = ex_q.rd;
   assign rd1_e       = ex_q.rd1;
   assign rd2_e       = ex_q.rd2;
   assign ctrl_e      = ex_q.ctrl;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pl_id_ex_stage.sv
// Directed bench for pl_id_ex_stage: vector table plus reset, bypass and saturation sequences.
module tb_pl_id_ex_stage;
   localparam int WAD = 5;
   localparam int WD  = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           valid_d, use_rs1_d, use_rs2_d, reg_write_w, flush_e;
   logic [WD-1:0]  pc_d, imm_d, rd1_d, rd2_d, result_w;
   logic [WAD-1:0] rs1_d, rs2_d, rd_d, rd_w;
   logic [11:0]    ctrl_d;
   logic           stall_d, valid_e;
   logic [WD-1:0]  pc_e, imm_e, rd1_e, rd2_e;
   logic [WAD-1:0] rs1_e, rs2_e, rd_e;
   logic [11:0]    ctrl_e;
   logic [15:0]    stall_count;

   pl_id_ex_stage #(.WAD(WAD), .WD(WD)) dut (
      .clk(clk), .rst(rst), .valid_d(valid_d), .pc_d(pc_d), .imm_d(imm_d),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .use_rs1_d(use_rs1_d),
      .use_rs2_d(use_rs2_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .ctrl_d(ctrl_d),
      .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w), .flush_e(flush_e),
      .stall_d(stall_d), .valid_e(valid_e), .pc_e(pc_e), .imm_e(imm_e),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
      .ctrl_e(ctrl_e), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] pc, imm;
      logic [4:0]  rs1, rs2, rd;
      logic        u1, u2;
      logic [31:0] rd1, rd2;
      logic [11:0] ctrl;
      logic        flush;
      logic        xstall;
      logic        xcap;
      logic [15:0] xcnt;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t tbl[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic u1, input logic u2, input logic [31:0] rd1,
                               input logic [31:0] rd2, input logic [11:0] ctrl, input logic fl,
                               input logic xs, input logic xc, input logic [15:0] xn);
      vec_t r;
      r.valid = v; r.pc = pc; r.imm = imm; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
      r.u1 = u1; r.u2 = u2; r.rd1 = rd1; r.rd2 = rd2; r.ctrl = ctrl; r.flush = fl;
      r.xstall = xs; r.xcap = xc; r.xcnt = xn;
      return r;
   endfunction

   task automatic drive(input vec_t v);
      valid_d = v.valid; pc_d = v.pc; imm_d = v.imm; rs1_d = v.rs1; rs2_d = v.rs2;
      rd_d = v.rd; use_rs1_d = v.u1; use_rs2_d = v.u2; rd1_d = v.rd1; rd2_d = v.rd2;
      ctrl_d = v.ctrl; flush_e = v.flush;
   endtask

   task automatic check_outs(input string t, input vec_t v);
      chk({t, ".valid_e"}, 32'(valid_e), v.xcap ? 32'd1 : 32'd0);
      chk({t, ".pc_e"},    pc_e,          v.xcap ? v.pc  : 32'd0);
      chk({t, ".imm_e"},   imm_e,         v.xcap ? v.imm : 32'd0);
      chk({t, ".rs1_e"},   32'(rs1_e),    v.xcap ? 32'(v.rs1) : 32'd0);
      chk({t, ".rs2_e"},   32'(rs2_e),    v.xcap ? 32'(v.rs2) : 32'd0);
      chk({t, ".rd_e"},    32'(rd_e),     v.xcap ? 32'(v.rd)  : 32'd0);
      chk({t, ".rd1_e"},   rd1_e,         v.xcap ? v.rd1 : 32'd0);
      chk({t, ".rd2_e"},   rd2_e,         v.xcap ? v.rd2 : 32'd0);
      chk({t, ".ctrl_e"},  32'(ctrl_e),   v.xcap ? 32'(v.ctrl) : 32'd0);
      chk({t, ".stall_count"}, 32'(stall_count), 32'(v.xcnt));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t lw6, add6, nop, byp;
      lw6  = mk(1, 32'h200, 0, 1, 0, 6, 1, 0, 1, 0, 12'hC04, 0, 0, 1, 0);
      add6 = mk(1, 32'h204, 0, 6, 2, 7, 1, 1, 22, 33, 12'h800, 0, 0, 1, 0);
      nop  = mk(1, 32'h208, 4, 1, 2, 3, 1, 1, 5, 7, 12'h800, 0, 0, 1, 0);

      tbl[0]  = mk(1, 32'h100, 4, 1, 2, 3, 1, 1, 32'h5, 7, 12'h800, 0, 0, 1, 0);
      tbl[1]  = mk(1, 32'h104, 8, 1, 0, 6, 1, 0, 11, 0, 12'hC04, 0, 0, 1, 0);
      tbl[2]  = mk(1, 32'h108, 0, 6, 2, 7, 1, 1, 22, 33, 12'h800, 0, 1, 0, 1);
      tbl[3]  = mk(1, 32'h108, 0, 6, 2, 7, 1, 1, 22, 33, 12'h800, 0, 0, 1, 1);
      tbl[4]  = mk(1, 32'h10C, 0, 3, 0, 0, 1, 0, 3, 0, 12'hC04, 0, 0, 1, 1);
      tbl[5]  = mk(1, 32'h110, 0, 0, 0, 5, 1, 1, 0, 0, 12'h800, 0, 0, 1, 1);
      tbl[6]  = mk(1, 32'h114, 0, 1, 0, 7, 1, 0, 1, 0, 12'hC04, 0, 0, 1, 1);
      tbl[7]  = mk(1, 32'h118, 0, 3, 7, 8, 1, 0, 1, 2, 12'h800, 0, 0, 1, 1);
      tbl[8]  = mk(1, 32'h11C, 0, 1, 0, 6, 1, 0, 1, 0, 12'hC04, 0, 0, 1, 1);
      tbl[9]  = mk(1, 32'h120, 0, 6, 2, 7, 1, 1, 22, 33, 12'h800, 1, 0, 0, 1);
      tbl[10] = mk(0, 32'h124, 0, 1, 2, 3, 1, 1, 99, 0, 12'h800, 0, 0, 0, 1);
      tbl[11] = mk(1, 32'h128, 0, 1, 0, 9, 1, 0, 1, 0, 12'hC04, 0, 0, 1, 1);
      tbl[12] = mk(1, 32'h12C, 0, 1, 9, 4, 1, 1, 1, 2, 12'h8A0, 0, 1, 0, 2);
      tbl[13] = mk(1, 32'h12C, 0, 1, 9, 4, 1, 1, 1, 2, 12'h8A0, 0, 0, 1, 2);
      tbl[14] = mk(1, 32'h130, 0, 1, 0, 9, 1, 0, 1, 0, 12'hC04, 0, 0, 1, 2);
      tbl[15] = mk(0, 32'h134, 0, 9, 0, 4, 1, 0, 0, 0, 12'h800, 0, 0, 0, 2);

      reg_write_w = 0; rd_w = 0; result_w = 0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1;
      #1;
      chk("reset.valid_e", 32'(valid_e), 0);
      chk("reset.ctrl_e", 32'(ctrl_e), 0);
      chk("reset.pc_e", pc_e, 0);
      chk("reset.stall_count", 32'(stall_count), 0);
      chk("reset.stall_d", 32'(stall_d), 0);
      repeat (2) @(negedge clk);
      rst = 0;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk($sformatf("row%0d.stall_d", i), 32'(stall_d), 32'(tbl[i].xstall));
         @(posedge clk);
         #1;
         check_outs($sformatf("row%0d", i), tbl[i]);
      end

      // Three more load-use pairs bring the counter to 5.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); drive(lw6);
         @(negedge clk); drive(add6);
         #1 chk($sformatf("pair%0d.stall_d", k), 32'(stall_d), 1);
         @(posedge clk);
         #1 chk($sformatf("pair%0d.stall_count", k), 32'(stall_count), 32'(3 + k));
      end
      @(negedge clk); drive(nop);
      @(posedge clk);
      #1;
      chk("prerst.valid_e", 32'(valid_e), 1);
      chk("prerst.stall_count", 32'(stall_count), 5);
      #2 rst = 1;
      #1;
      chk("asyncrst.valid_e", 32'(valid_e), 0);
      chk("asyncrst.pc_e", pc_e, 0);
      chk("asyncrst.rd1_e", rd1_e, 0);
      chk("asyncrst.ctrl_e", 32'(ctrl_e), 0);
      chk("asyncrst.stall_count", 32'(stall_count), 0);
      @(negedge clk); drive(lw6);
      @(posedge clk);
      #1;
      chk("rsthold.valid_e", 32'(valid_e), 0);
      chk("rsthold.pc_e", pc_e, 0);
      @(negedge clk); rst = 0;
      @(posedge clk);
      @(negedge clk); drive(add6);
      #1 chk("midstall.stall_d", 32'(stall_d), 1);
      rst = 1;
      #1;
      chk("midstall.rst_stall_d", 32'(stall_d), 0);
      chk("midstall.rst_valid_e", 32'(valid_e), 0);
      @(negedge clk); rst = 0;
      #1 chk("midstall.rel_stall_d", 32'(stall_d), 0);
      @(posedge clk);
      #1;
      chk("midstall.cap_valid_e", 32'(valid_e), 1);
      chk("midstall.cap_pc_e", pc_e, 32'h204);
      chk("midstall.stall_count", 32'(stall_count), 0);

      byp = mk(1, 32'h300, 0, 10, 3, 11, 1, 1, 32'h0, 32'h3, 12'h800, 0, 0, 1, 0);
      @(negedge clk);
      drive(byp);
      reg_write_w = 1; rd_w = 10; result_w = 32'hDEAD;
      @(posedge clk);
      #1;
`ifdef ID_WB_BYPASS_EN
      chk("bypass.rd1_e", rd1_e, 32'hDEAD);
`else
      chk("bypass.rd1_e", rd1_e, 32'h0);
`endif
      chk("bypass.rd2_e", rd2_e, 32'h3);
      @(negedge clk);
      reg_write_w = 0; rd_w = 0; result_w = 0;

      // Saturation: preload the counter near the top instead of running 65k stall cycles.
      drive(nop);
      force dut.stall_count_q = 16'hFFFD;
      #1 release dut.stall_count_q;
      @(posedge clk);
      lw6.rs1 = 6;
      for (int k = 0; k < 6; k++) begin
         logic [15:0] xc;
         @(negedge clk); drive(lw6);
         #1 chk($sformatf("sat%0d.stall_d", k), 32'(stall_d), 32'(k % 2));
         @(posedge clk);
         xc = (k < 1) ? 16'hFFFD : (k < 3) ? 16'hFFFE : 16'hFFFF;
         #1 chk($sformatf("sat%0d.stall_count", k), 32'(stall_count), 32'(xc));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pl_id_ex_stage.md
PL_ID_EX_STAGE -- requirements
Module: pl_id_ex_stage

Interface
REQ-001 Parameter WAD, default 5, register address width.
REQ-002 Parameter WD, default 32, data width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 valid_d  in  1  decode slot holds a real instruction.
REQ-006 pc_d, imm_d  in  WD each  decode PC and sign-extended immediate.
REQ-007 rs1_d, rs2_d, rd_d  in  WAD each  source and destination register addresses.
REQ-008 use_rs1_d, use_rs2_d  in  1 each  instruction actually reads rs1 / rs2.
REQ-009 rd1_d, rd2_d  in  WD each  register-file read data for rs1_d / rs2_d.
REQ-010 ctrl_d  in  12  packed control: [11] reg_write, [10] mem_read, [9] mem_write, [8:5] alu_ctrl, [4] alu_src, [3:2] result_src, [1] branch, [0] jump.
REQ-011 reg_write_w, rd_w, result_w  in  1/WAD/WD  writeback-stage write port, same signals driven to the register file.
REQ-012 flush_e  in  1  taken branch/jump resolved in EX; decode slot is wrong-path.
REQ-013 stall_d  out  1  combinational; holds PC and decode registers this cycle.
REQ-014 valid_e, pc_e, imm_e, rs1_e, rs2_e, rd_e, rd1_e, rd2_e, ctrl_e  out  widths as decode-side counterparts  registered EX-stage copies.
REQ-015 stall_count  out  16  saturating count of cycles with stall_d=1.

Function
REQ-016 Load-use hazard = valid_d & valid_e & ctrl_e[10] & (rd_e!=0) & ((use_rs1_d & rs1_d==rd_e) | (use_rs2_d & rs2_d==rd_e)).
REQ-017 stall_d SHALL equal hazard & ~flush_e, with no registered delay.
REQ-018 Priority per cycle: flush_e > stall_d > normal capture.
REQ-019 Normal: at posedge, all _e outputs SHALL capture their _d inputs (rd1/rd2 per REQ-031); latency exactly one cycle.
REQ-020 Flush or stall: at posedge, EX register SHALL load a bubble: valid_e=0, ctrl_e=0, all data/address fields 0.
REQ-021 Stall SHALL last exactly one cycle per load-use pair, since the inserted bubble clears ctrl_e[10].
REQ-022 valid_d=0 in a normal cycle SHALL load a bubble identical to REQ-020.
REQ-023 Hazard check SHALL ignore register x0 and sources whose use_ flag is 0.
REQ-024 stall_count SHALL increment by 1 on each posedge where stall_d=1 and hold at 16'hFFFF.
REQ-025 Flush and hazard in same cycle: bubble loaded, stall_d=0, stall_count unchanged.

Reset
REQ-026 rst=1 SHALL immediately, without clk, force valid_e=0, ctrl_e=0, all data/address outputs 0, stall_count=0.
REQ-027 stall_d SHALL be 0 during reset, as valid_e=0.
REQ-028 Reset asserted mid-stall SHALL discard the pending bubble; first posedge after release performs a normal capture.
REQ-029 No state SHALL change on clk while rst=1.

Configuration
REQ-030 Macro ID_WB_BYPASS_EN compiles in the writeback-to-decode bypass.
REQ-031 Defined: if reg_write_w & rd_w!=0 & rd_w==rs1_d, rd1_e SHALL capture result_w instead of rd1_d; same for rs2_d/rd2_e.
REQ-032 Undefined: rd1_e/rd2_e SHALL always capture rd1_d/rd2_d; the register file's write-through covers same-cycle writes.
REQ-033 Macro SHALL NOT affect hazard detection, stall_d or stall_count.

Verification
REQ-034 Normal: valid_d=1, pc_d=0x100, rd1_d=0x5, ctrl_d=0x800 -> next cycle pc_e=0x100, rd1_e=0x5, ctrl_e=0x800, valid_e=1.
REQ-035 Load-use: EX holds lw rd_e=6; decode add rs1_d=6, use_rs1_d=1 -> stall_d=1 one cycle, bubble in EX, add captured next cycle, stall_count=1.
REQ-036 x0 / unused source: lw rd_e=0 with rs1_d=0, and lw rd_e=7 with rs2_d=7 but use_rs2_d=0 -> stall_d=0 in both.
REQ-037 Flush+hazard: flush_e=1 during REQ-035 hazard -> stall_d=0, valid_e=0 next cycle, stall_count unchanged.
REQ-038 Bypass (macro defined): rd_w=10, result_w=0xDEAD, reg_write_w=1, rs1_d=10, rd1_d=0x0 -> rd1_e=0xDEAD; macro undefined -> rd1_e=0x0.
REQ-039 Reset: assert rst between clk edges with valid_e=1, stall_count=5 -> all outputs 0 immediately; saturation: force 65536 stall cycles -> stall_count=0xFFFF.
